// File: rtl/corner_judge_pkg.sv
// Shared types for the corner pass judge.
//   state_t      : FSM state codes exposed on the 'state' output.
//   corner_t     : corner index, 0=LT 1=RT 2=LB 3=RB.
//   LFSR_SEED    : reset value of the optional target LFSR.
//   rotation_corner : fixed target rotation LT, RT, RB, LB.
package corner_judge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_PLAY   = 3'd2,
    ST_HIT    = 3'd3,
    ST_MISS   = 3'd4,
    ST_RESULT = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CORNER_LT = 2'd0,
    CORNER_RT = 2'd1,
    CORNER_LB = 2'd2,
    CORNER_RB = 2'd3
  } corner_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Rotation LT, RT, RB, LB by round index mod 4.
  function automatic corner_t rotation_corner(input logic [1:0] idx);
    return corner_t'({idx[1], idx[1] ^ idx[0]});
  endfunction

endpackage

// File: rtl/corner_hold_counter.sv
// Per-corner consecutive-frame counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : frame tick; the counter only moves on this
//   pass         : corner pass flag sampled on tick
//   held         : counter equals HOLD_FRAMES once this cycle's tick is applied
module corner_hold_counter #(
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pass,
  output logic held
);

  localparam int unsigned W = $clog2(HOLD_FRAMES + 2);
  localparam logic [W-1:0] HOLD = W'(HOLD_FRAMES);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (tick) begin
      if (!pass)
        count_nxt = '0;
      else if (count != HOLD)
        count_nxt = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else
      count <= count_nxt;
  end

  // Looks at the post-update value so the FSM can act on the same frame
  // tick that completes the hold.
  assign held = (count_nxt == HOLD);

endmodule

// File: rtl/corner_pass_judge.sv
// Corner pass judge: runs a game of NUM_ROUNDS rounds in which the player
// must hold the target corner for HOLD_FRAMES consecutive frames within
// TIMEOUT_FRAMES frames.
// Ports:
//   clk, reset_n           : pixel clock, asynchronous active-low reset
//   vsync                  : frame sync; rising edge is the frame tick
//   pass_LT/RT/LB/RB       : per-frame corner pass flags
//   start, abort           : game start pulse, abort level
//   target_corner/_valid   : current target, valid while playing
//   state, round_idx, score, timer : status
//   hit_pulse, miss_pulse  : one-cycle result strobes
//   game_over              : high when the game has finished
// Build option: CORNER_LFSR_EN selects LFSR targets instead of the rotation.
module corner_pass_judge
  import corner_judge_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES    = 8,
  parameter int unsigned TIMEOUT_FRAMES = 180,
  parameter int unsigned NUM_ROUNDS     = 10,
  parameter int unsigned RESULT_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       pass_LT,
  input  logic       pass_RT,
  input  logic       pass_LB,
  input  logic       pass_RB,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] target_corner,
  output logic       target_valid,
  output logic [2:0] state,
  output logic [7:0] round_idx,
  output logic [7:0] score,
  output logic [7:0] timer,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  logic       vs_d;
  logic       frame_tick;
  logic [3:0] flags;
  logic [3:0] held;

  state_t     cur_state, nxt_state;
  corner_t    target, target_nxt, next_target;
  logic [7:0] round_nxt, score_nxt;
  logic [15:0] timer_cnt, timer_nxt;
  logic [15:0] res_cnt, res_nxt;

  assign frame_tick = vsync & ~vs_d;
  assign flags      = {pass_RB, pass_LB, pass_RT, pass_LT};

  for (genvar i = 0; i < 4; i++) begin : g_hold
    corner_hold_counter #(.HOLD_FRAMES(HOLD_FRAMES)) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (frame_tick),
      .pass    (flags[i]),
      .held    (held[i])
    );
  end

`ifdef CORNER_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Never repeat the previous target.
  assign next_target = (corner_t'(lfsr[1:0]) == target) ? corner_t'(lfsr[1:0] + 2'd1)
                                                       : corner_t'(lfsr[1:0]);
`else
  assign next_target = rotation_corner(round_idx[1:0]);
`endif

  always_comb begin
    nxt_state  = cur_state;
    target_nxt = target;
    round_nxt  = round_idx;
    score_nxt  = score;
    timer_nxt  = timer_cnt;
    res_nxt    = res_cnt;
    if (abort) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            nxt_state = ST_ARM;
            round_nxt = '0;
            score_nxt = '0;
          end
        end
        ST_ARM: begin
          // An all-zero frame is required so a hold can't carry into the round.
          if (frame_tick && flags == 4'd0) begin
            target_nxt = next_target;
            timer_nxt  = 16'(TIMEOUT_FRAMES);
            nxt_state  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (held[target])
              nxt_state = ST_HIT;
            else if (held != 4'd0 || timer_cnt <= 16'd1)
              nxt_state = ST_MISS;
            else
              timer_nxt = timer_cnt - 16'd1;
          end
        end
        ST_HIT: begin
          if (score != 8'hFF)
            score_nxt = score + 8'd1;
          res_nxt   = 16'(RESULT_FRAMES);
          nxt_state = ST_RESULT;
        end
        ST_MISS: begin
          res_nxt   = 16'(RESULT_FRAMES);
          nxt_state = ST_RESULT;
        end
        ST_RESULT: begin
          if (frame_tick) begin
            if (res_cnt <= 16'd1) begin
              res_nxt = '0;
              if (round_idx == 8'(NUM_ROUNDS - 1)) begin
                nxt_state = ST_DONE;
              end else begin
                round_nxt = round_idx + 8'd1;
                nxt_state = ST_ARM;
              end
            end else begin
              res_nxt = res_cnt - 16'd1;
            end
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d      <= 1'b0;
      cur_state <= ST_IDLE;
      target    <= CORNER_LT;
      round_idx <= '0;
      score     <= '0;
      timer_cnt <= '0;
      res_cnt   <= '0;
    end else begin
      vs_d      <= vsync;
      cur_state <= nxt_state;
      target    <= target_nxt;
      round_idx <= round_nxt;
      score     <= score_nxt;
      timer_cnt <= timer_nxt;
      res_cnt   <= res_nxt;
    end
  end

  assign state         = cur_state;
  assign target_corner = target;
  assign target_valid  = (cur_state == ST_PLAY);
  assign hit_pulse     = (cur_state == ST_HIT);
  assign miss_pulse    = (cur_state == ST_MISS);
  assign game_over     = (cur_state == ST_DONE);
  assign timer         = (timer_cnt > 16'd255) ? 8'hFF : timer_cnt[7:0];

endmodule

// File: tb/tb_corner_pass_judge.sv
module tb_corner_pass_judge;

  localparam int HOLD = 8;
  localparam int TMO  = 180;
  localparam int NR   = 2;
  localparam int RES  = 30;

  // spec state codes
  localparam int C_IDLE = 0, C_ARM = 1, C_PLAY = 2, C_RESULT = 5, C_DONE = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic vsync = 1'b0;
  logic pass_LT = 1'b0, pass_RT = 1'b0, pass_LB = 1'b0, pass_RB = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [1:0] target_corner;
  logic target_valid;
  logic [2:0] state;
  logic [7:0] round_idx, score, timer;
  logic hit_pulse, miss_pulse, game_over;

  corner_pass_judge #(
    .HOLD_FRAMES(HOLD), .TIMEOUT_FRAMES(TMO), .NUM_ROUNDS(NR), .RESULT_FRAMES(RES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync),
    .pass_LT(pass_LT), .pass_RT(pass_RT), .pass_LB(pass_LB), .pass_RB(pass_RB),
    .start(start), .abort(abort),
    .target_corner(target_corner), .target_valid(target_valid), .state(state),
    .round_idx(round_idx), .score(score), .timer(timer),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  int m_mode, m_round, m_score, m_timer, m_res, m_target;
  int streak[4];
  int exp_hit, exp_miss;
  int hit_seen, miss_seen;
  int rot[4] = '{0, 1, 3, 2};

  always @(negedge clk) begin
    if (hit_pulse === 1'b1) hit_seen++;
    if (miss_pulse === 1'b1) miss_seen++;
  end

  task automatic m_reset();
    m_mode = C_IDLE; m_round = 0; m_score = 0; m_timer = 0; m_res = 0; m_target = 0;
    for (int i = 0; i < 4; i++) streak[i] = 0;
  endtask

  task automatic m_tick(input logic [3:0] f);
    bit any_full;
    exp_hit = 0; exp_miss = 0; any_full = 0;
    for (int i = 0; i < 4; i++) begin
      streak[i] = f[i] ? ((streak[i] < HOLD) ? streak[i] + 1 : HOLD) : 0;
      if (streak[i] == HOLD) any_full = 1;
    end
    if (m_mode == C_ARM) begin
      if (f == 4'd0) begin
        m_target = rot[m_round % 4];
        m_timer  = TMO;
        m_mode   = C_PLAY;
      end
    end else if (m_mode == C_PLAY) begin
      if (streak[m_target] == HOLD) begin
        exp_hit = 1;
        if (m_score < 255) m_score++;
        m_mode = C_RESULT; m_res = RES;
      end else if (any_full || m_timer == 1) begin
        exp_miss = 1;
        m_mode = C_RESULT; m_res = RES;
      end else begin
        m_timer--;
      end
    end else if (m_mode == C_RESULT) begin
      m_res--;
      if (m_res == 0) begin
        if (m_round == NR - 1) m_mode = C_DONE;
        else begin m_round++; m_mode = C_ARM; end
      end
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), m_mode);
    check("valid", 32'(target_valid), (m_mode == C_PLAY) ? 1 : 0);
    check("over", 32'(game_over), (m_mode == C_DONE) ? 1 : 0);
    check("target", 32'(target_corner), m_target);
    check("round", 32'(round_idx), m_round);
    check("score", 32'(score), m_score);
    check("timer", 32'(timer), (m_timer > 255) ? 255 : m_timer);
    check("hit_cycles", hit_seen, exp_hit);
    check("miss_cycles", miss_seen, exp_miss);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic frame(input logic [3:0] f);
    hit_seen = 0; miss_seen = 0;
    @(negedge clk);
    vsync = 1'b1;
    {pass_RB, pass_LB, pass_RT, pass_LT} = f;
    @(negedge clk);
    @(negedge clk);
    {pass_RB, pass_LB, pass_RT, pass_LT} = 4'd0;
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    m_tick(f);
    check_all();
  endtask

  task automatic frames(input logic [3:0] f, input int n);
    for (int i = 0; i < n; i++) frame(f);
  endtask

  task automatic give_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (m_mode == C_IDLE || m_mode == C_DONE) begin
      m_mode = C_ARM; m_round = 0; m_score = 0;
    end
  endtask

  task automatic give_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    m_mode = C_IDLE;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  logic [3:0] run_f;
  int run_left;
  logic [3:0] one_hot;

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_score", 32'(score), 0);
    check("rst_valid", 32'(target_valid), 0);
    reset_n = 1'b1;

    // win on the 8th LT frame
    give_start();
    frame(4'd0);
    frames(4'b0001, HOLD);
    check("dir_hit_score", 32'(score), 1);

    // wrong corner held in round 0
    give_abort();
    give_start();
    frame(4'd0);
    frames(4'b0010, HOLD);
    check("dir_wrong_score", 32'(score), 0);
    check("dir_wrong_state", 32'(state), C_RESULT);

    // timeout
    give_abort();
    give_start();
    frame(4'd0);
    frames(4'd0, TMO - 1);
    check("dir_tmo_timer", 32'(timer), 1);
    check("dir_tmo_play", 32'(state), C_PLAY);
    frame(4'd0);
    check("dir_tmo_state", 32'(state), C_RESULT);

    // broken hold, then full hold; then a second round and game over
    give_abort();
    give_start();
    frame(4'd0);
    frames(4'b0001, HOLD - 1);
    frame(4'd0);
    frames(4'b0001, HOLD - 1);
    check("dir_break_score", 32'(score), 0);
    frame(4'b0001);
    check("dir_break_hit", 32'(score), 1);
    frames(4'd0, RES);
    frame(4'd0);
    check("dir_r1_target", 32'(target_corner), 1);
    frames(4'b0010, HOLD);
    frames(4'd0, RES);
    check("dir_over", 32'(game_over), 1);
    check("dir_over_score", 32'(score), 2);
    give_start();
    check("dir_restart_score", 32'(score), 0);
    check("dir_restart_state", 32'(state), C_ARM);

    // abort while showing the result
    frame(4'd0);
    frames(4'b0001, HOLD);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check("dir_abort_idle", 32'(state), C_IDLE);
    @(negedge clk); abort = 1'b0;
    m_mode = C_IDLE;

    // reset while playing
    give_start();
    frame(4'd0);
    frames(4'b0100, 3);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("dir_rst_state", 32'(state), 0);
    check("dir_rst_valid", 32'(target_valid), 0);
    check("dir_rst_timer", 32'(timer), 0);
    check("dir_rst_target", 32'(target_corner), 0);
    m_reset();
    @(negedge clk); reset_n = 1'b1;

    // randomized play
    run_left = 0;
    run_f = 4'd0;
    for (int fr = 0; fr < 1200; fr++) begin
      int r;
      r = $urandom_range(0, 399);
      if (r == 0) apply_reset();
      else if (r < 4) give_abort();
      else if (r < 12 || m_mode == C_IDLE || m_mode == C_DONE) give_start();
      if (run_left == 0) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) begin
          one_hot = 4'b0001;
          run_f = one_hot << $urandom_range(0, 3);
          run_left = $urandom_range(1, 10);
        end else if (k < 8) begin
          run_f = 4'd0;
          run_left = $urandom_range(1, 4);
        end else begin
          run_f = 4'($urandom_range(0, 15));
          run_left = 1;
        end
      end
      frame(run_f);
      run_left--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corner_pass_judge.md
CORNER_PASS_JUDGE -- requirements
Module: corner_pass_judge

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 8: consecutive passing frames before a corner counts as held.
REQ-002 SHALL have parameter TIMEOUT_FRAMES, default 180: frames allowed per round.
REQ-003 SHALL have parameter NUM_ROUNDS, default 10, legal 1..255: rounds per game.
REQ-004 SHALL have parameter RESULT_FRAMES, default 30: frames the hit/miss result is displayed.
REQ-005 SHALL have ports:
- clk  in  1: pixel clock.
- reset_n  in  1: asynchronous, active-low reset.
- vsync  in  1: frame sync, same as the colour detector input.
- pass_LT, pass_RT, pass_LB, pass_RB  in  1 each: per-frame corner pass flags from the colour detector.
- start  in  1: one-cycle game start pulse.
- abort  in  1: level; return to idle.
- target_corner  out  2: 0=LT, 1=RT, 2=LB, 3=RB.
- target_valid  out  1: a target is live in PLAY.
- state  out  3: FSM state code.
- round_idx  out  8: current round, 0-based.
- score  out  8: number of hits.
- timer  out  8: frames left in the round, saturating display copy.
- hit_pulse, miss_pulse  out  1 each: one-cycle result strobes.
- game_over  out  1: high in DONE.

Function
REQ-006 SHALL register vsync into vs_d; frame_tick = vsync & ~vs_d (combinational), so it is high on the first vsync-high cycle.
REQ-007 SHALL snapshot the four pass flags on frame_tick, before the detector clears them (detector clear lands 2 cycles later).
REQ-008 SHALL keep a per-corner consecutive-frame counter, updated only on frame_tick:
- snapshot 1: increment, saturating at HOLD_FRAMES.
- snapshot 0: clear to 0.
- held[i] = (counter == HOLD_FRAMES).
REQ-009 SHALL implement FSM states IDLE=0, ARM=1, PLAY=2, HIT=3, MISS=4, RESULT=5, DONE=6.
REQ-010 IDLE: start -> ARM, with round_idx=0 and score=0.
REQ-011 ARM: on a frame_tick whose snapshot is all zero, SHALL latch the next target, load the timer with TIMEOUT_FRAMES, and go to PLAY. A nonzero snapshot keeps ARM, which prevents carry-over holds.
REQ-012 PLAY: on each frame_tick, priority order:
- held[target]: go to HIT.
- else any other held corner: go to MISS.
- else timer==1: go to MISS.
- else timer decrements.
REQ-013 HIT SHALL last 1 cycle: score+1 (saturating at 255), hit_pulse=1, go to RESULT with the result counter loaded with RESULT_FRAMES.
REQ-014 MISS SHALL last 1 cycle: miss_pulse=1, go to RESULT as in HIT.
REQ-015 RESULT: decrement on frame_tick. On reaching 0, go to DONE if round_idx==NUM_ROUNDS-1, else round_idx+1 and go to ARM.
REQ-016 DONE: game_over=1; start -> ARM with round_idx=0 and score=0.
REQ-017 start SHALL be ignored outside IDLE and DONE.
REQ-018 abort SHALL force IDLE from any state on the next clock, overriding all other transitions.
REQ-019 target_valid SHALL equal (state==PLAY); target_corner SHALL hold its value outside PLAY.
REQ-020 When frame_tick and start coincide in IDLE, start SHALL win; the snapshot is still taken.
REQ-021 timer output SHALL equal the internal timer clipped to 255.

Reset
REQ-022 On reset_n low, SHALL asynchronously set:
- state=IDLE.
- vs_d=0.
- all counters, snapshot, score, round_idx and timer = 0.
- target_corner=0.
- pulses, target_valid and game_over = 0.
REQ-023 Reset mid-game SHALL abandon the game with no pulse emitted.

Configuration
REQ-024 With CORNER_LFSR_EN defined, the target SHALL come from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5). The LFSR advances every clock and the target is its bits [1:0] sampled in ARM. A target equal to the previous target SHALL be incremented modulo 4.
REQ-025 Without CORNER_LFSR_EN, the target SHALL follow the fixed rotation LT, RT, RB, LB, indexed by round_idx mod 4.

Structure
REQ-026 A shared package corner_judge_pkg SHALL hold the state enum, the corner enum (LT/RT/LB/RB), and the LFSR seed constant.
REQ-027 The per-corner hold counter SHALL be a sub-module, corner_hold_counter, instantiated 4 times.

Verification
REQ-028 Defaults, fixed rotation: start, then 1 empty frame, then pass_LT for 8 frames -> HIT on the 8th frame_tick; score=1; hit_pulse is exactly 1 cycle.
REQ-029 Round 0: pass_RT held 8 frames -> MISS (wrong corner); score stays 0.
REQ-030 No pass flags for 180 frames in PLAY -> MISS on frame 180; timer reaches 1, then the state goes to RESULT.
REQ-031 pass_LT high 7 frames, 1 frame low, then 7 frames high -> no HIT. The 8th consecutive frame -> HIT.
REQ-032 NUM_ROUNDS=2, both rounds hit -> game_over=1 and score=2 after 30 result frames. start then restarts with score=0.
REQ-033 Assert reset_n low during PLAY -> all outputs at reset values immediately. abort during RESULT -> IDLE on the next clock.
